uart_tx_pio: RTL and testbench
==============================

Name: uart_tx_pio

Overview:
- Bus-mapped UART transmitter peripheral on the shared CPU bus (8-bit data, 13-bit address, wr/rd strobes).
- Sits downstream of the RISC core, alongside the memories and the pio block.
- Consumes CPU byte writes into a small TX FIFO and serialises them as 8N1 frames on txd.
- Exposes a read-only status register for software polling.

Parameters:
- BASE_ADDR, 13'h1FF0, address of TXDATA register; STATUS register is at BASE_ADDR+1.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  core clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- bus_data  inout  8  CPU data bus; driven only during a STATUS read, otherwise high-Z.
- bus_addr  input  13  CPU address bus.
- wr  input  1  CPU write strobe, level, may be held for multiple cycles.
- rd  input  1  CPU read strobe, level.
- txd  output  1  serial output; idle high.
- tx_idle  output  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers and count are cleared.
  - FSM goes to IDLE; txd=1, tx_idle=1, overflow=0.
  - Reset mid-frame aborts the frame; txd=1 on the next cycle.
- Write detect:
  - wr_d is a registered copy of wr.
  - A push event is wr=1 && wr_d=0 && bus_addr==BASE_ADDR.
  - Exactly one push per strobe, regardless of strobe length.
  - Writes to BASE_ADDR+1 and to any other address are ignored.
- Push:
  - If count<FIFO_DEPTH, bus_data is written at the write pointer, wptr increments (wraps modulo FIFO_DEPTH), and count increments.
  - If count==FIFO_DEPTH, the byte is dropped and overflow is set (sticky).
  - Fullness is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs that cycle.
- Status read:
  - While rd=1 && bus_addr==BASE_ADDR+1, bus_data is driven combinationally with {4'b0, overflow, busy, empty, full}.
  - full = (count==FIFO_DEPTH); empty = (count==0); busy = (FSM!=IDLE).
  - A read of BASE_ADDR returns high-Z; the block does not drive it.
  - overflow clears on the rd rising edge of a STATUS read (rd=1, rd_d=0, address match), i.e. after the value has been presented.
  - If a clear and a new overflow occur in the same cycle, set wins.
- TX FSM (baud counter bcnt, bit index bidx, shift register sh):
  - IDLE: txd=1. If count>0, pop the FIFO head into sh, rptr++, count--, bcnt=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then bidx=0, go to DATA.
  - DATA: txd=sh[0], LSB first. Every CLKS_PER_BIT cycles, sh>>=1 and bidx++. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - No gap is added between frames: if the FIFO is non-empty, IDLE lasts exactly 1 cycle before the next START.
  - A simultaneous push and pop in one cycle gives net count unchanged; both pointers advance.
- Latency: a push at edge N into an empty FIFO with an idle FSM gives a pop at edge N+1, and txd falls in the cycle after edge N+1.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frame period: 10*CLKS_PER_BIT+1 cycles.
- txd is registered and glitch-free.
- tx_idle = empty && (FSM==IDLE), registered.

Test Plan:
- Reset check: rst=1 for 3 cycles, then release -> txd=1, tx_idle=1, STATUS read returns 8'h02 (empty only).
- Single byte: write 8'hA5 to 13'h1FF0 -> txd falls 2 cycles after the strobe edge, then bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high 16 cycles; tx_idle returns to 1 after 160 cycles.
- Held strobe: wr held 5 cycles with 8'h3C -> exactly one frame sent; STATUS during the frame reads 8'h06 (busy, empty).
- Fill and overflow: 6 rapid writes 8'h01..8'h06:
  - The first is popped immediately, so 8'h02..8'h05 fill the FIFO and STATUS=8'h05.
  - 8'h06 is dropped, and STATUS=8'h0D (overflow, busy, full).
  - A second STATUS read returns 8'h05.
  - Bytes 01,02,03,04,05 are serialised in order with 161-cycle period.
- Reset mid-frame: assert rst during the DATA bit 3 of 8'hFF -> txd=1 the next cycle, STATUS=8'h02, no further frames after release.
- Bus hygiene: a read of an unrelated address, or rd=0 -> bus_data is high-Z. A write to 13'h1FF1 -> no push, count unchanged.

Source files
------------

// File: rtl/uart_tx_pio.sv
// uart_tx_pio: bus-mapped 8N1 UART transmitter with a small TX FIFO and a polled status register
module uart_tx_pio #(
    parameter logic [12:0] BASE_ADDR    = 13'h1FF0,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [7:0]  bus_data,
    input  logic [12:0] bus_addr,
    input  logic        wr,
    input  logic        rd,
    output logic        txd,
    output logic        tx_idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nxt;
    logic [BW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    sh;
    logic          wr_d, rd_d, overflow;
    logic          full, empty, push, do_push, pop, stat_sel, bit_end;

    assign full      = count == DEPTH;
    assign empty     = count == '0;
    assign push      = wr && !wr_d && bus_addr == BASE_ADDR;
    assign do_push   = push && !full;
    assign pop       = state == IDLE && !empty;
    assign stat_sel  = rd && bus_addr == BASE_ADDR + 13'd1;
    assign bit_end   = bcnt == BLAST;
    assign count_nxt = count + CW'(do_push) - CW'(pop);
    assign bus_data  = stat_sel ? {4'b0, overflow, state != IDLE, empty, full} : 8'bz;

    always_ff @(posedge clk) begin
        wr_d <= wr;
        if (do_push) mem[wptr] <= bus_data;
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_d     <= 1'b0;
        end else begin
            rd_d  <= rd;
            count <= count_nxt;
            if (do_push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            // a new drop in the same cycle as the read-clear keeps the flag set
            if (push && full) overflow <= 1'b1;
            else if (stat_sel && !rd_d) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_idle <= 1'b1;
            bcnt    <= '0;
            bidx    <= '0;
            sh      <= '0;
        end else begin
            bcnt    <= (state == IDLE || bit_end) ? '0 : bcnt + BW'(1);
            tx_idle <= 1'b0;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        sh    <= mem[rptr];
                        state <= START;
                        txd   <= 1'b0;
                    end else begin
                        tx_idle <= count_nxt == '0;
                    end
                end
                START: if (bit_end) begin
                    state <= DATA;
                    bidx  <= '0;
                    txd   <= sh[0];
                end
                DATA: if (bit_end) begin
                    if (bidx == 3'd7) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end else begin
                        sh   <= sh >> 1;
                        bidx <= bidx + 3'd1;
                        txd  <= sh[1];
                    end
                end
                STOP: if (bit_end) begin
                    state   <= IDLE;
                    tx_idle <= count_nxt == '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_pio.sv
// tb_uart_tx_pio: frame-decoding scoreboard plus table-driven bus checks for uart_tx_pio
module tb_uart_tx_pio;
    localparam int C = 16;
    localparam logic [12:0] BASE = 13'h1FF0;

    typedef struct {
        logic [12:0] addr;
        logic        rd;
        logic [7:0]  exp;
    } rvec_t;

    logic        clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, drv_en = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  drv = '0;
    wire  [7:0]  bus_data;
    logic        txd, tx_idle;
    int          total = 0, passed = 0, cyc = 0;
    logic [7:0]  exp_q[$];
    int          falls[$];
    rvec_t       tbl[6];

    assign bus_data = drv_en ? drv : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (bus_data[i]);
    end

    uart_tx_pio dut (
        .clk(clk), .rst(rst), .bus_data(bus_data), .bus_addr(addr),
        .wr(wr), .rd(rd), .txd(txd), .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    task automatic bus_write(input logic [12:0] a, input logic [7:0] d, input int len);
        @(negedge clk);
        addr = a;
        drv = d;
        drv_en = 1'b1;
        wr = 1'b1;
        repeat (len) @(negedge clk);
        wr = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic status_read(input string name, input logic [7:0] exp);
        @(negedge clk);
        addr = BASE + 13'd1;
        rd = 1'b1;
        #1 chk(name, bus_data, exp);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (!tx_idle && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, tx_idle, 1);
    endtask

    task automatic quiet(input string name, input int len);
        int lows = 0;
        repeat (len) begin
            @(negedge clk);
            if (!txd) lows++;
        end
        chk(name, lows, 0);
    endtask

    // Decode every frame at bit centres; frames cut short by reset are discarded.
    initial begin : monitor
        logic       prev;
        logic [9:0] bits;
        logic       aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !txd && !rst) begin
                falls.push_back(cyc);
                aborted = 1'b0;
                bits = '0;
                for (int c = 0; c < 10 * C; c++) begin
                    if (c > 0) @(negedge clk);
                    aborted |= rst;
                    if (c % C == C / 2) bits[c / C] = txd;
                end
                if (!aborted) begin
                    chk("frame_start_bit", bits[0], 0);
                    chk("frame_stop_bit", bits[9], 1);
                    chk("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("frame_byte", bits[8:1], exp_q.pop_front());
                end
            end
            prev = txd;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0] = '{BASE + 13'd1, 1'b1, 8'h02};
        tbl[1] = '{BASE,         1'b1, 8'hFF};
        tbl[2] = '{13'h0000,     1'b1, 8'hFF};
        tbl[3] = '{BASE + 13'd1, 1'b0, 8'hFF};
        tbl[4] = '{BASE + 13'd2, 1'b1, 8'hFF};
        tbl[5] = '{13'h0FF1,     1'b1, 8'hFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_txd", txd, 1);
        chk("reset_tx_idle", tx_idle, 1);
        status_read("reset_status", 8'h02);

        exp_q.push_back(8'hA5);
        bus_write(BASE, 8'hA5, 1);
        chk("a5_txd_before_start", txd, 1);
        chk("a5_tx_idle_low", tx_idle, 0);
        @(negedge clk);
        chk("a5_start_low", txd, 0);
        n = 0;
        while (!tx_idle && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("a5_idle_after_cycles", n, 160);

        exp_q.push_back(8'h3C);
        bus_write(BASE, 8'h3C, 5);
        status_read("held_status_busy", 8'h06);
        wait_idle("held_idle", 400);
        chk("held_one_frame", exp_q.size(), 0);

        falls.delete();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            bus_write(BASE, 8'(i), 1);
        end
        status_read("fill_status_full", 8'h05);
        bus_write(BASE, 8'h06, 1);
        status_read("fill_status_overflow", 8'h0D);
        status_read("fill_status_cleared", 8'h05);
        wait_idle("fill_idle", 1200);
        chk("fill_all_sent", exp_q.size(), 0);
        chk("fill_frame_count", falls.size(), 5);
        for (int i = 1; i < falls.size(); i++)
            chk($sformatf("fill_period%0d", i), falls[i] - falls[i-1], 10 * C + 1);

        exp_q.push_back(8'hFF);
        bus_write(BASE, 8'hFF, 1);
        n = 0;
        while (txd && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ff_start_seen", txd, 0);
        repeat (4 * C + C / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ff_rst_txd", txd, 1);
        chk("ff_rst_tx_idle", tx_idle, 1);
        rst = 1'b0;
        exp_q.delete();
        status_read("ff_rst_status", 8'h02);
        quiet("ff_no_more_frames", 300);

        bus_write(BASE, 8'h00, 1);
        repeat (5) @(negedge clk);
        chk("zero_in_start", txd, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("zero_rst_txd", txd, 1);
        rst = 1'b0;
        quiet("zero_no_more_frames", 200);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            addr = tbl[i].addr;
            rd = tbl[i].rd;
            #1 chk($sformatf("bus_vec%0d", i), bus_data, tbl[i].exp);
            @(negedge clk);
            rd = 1'b0;
        end

        bus_write(BASE + 13'd1, 8'h77, 1);
        bus_write(13'h0000, 8'h55, 1);
        repeat (3) @(negedge clk);
        chk("ignored_write_tx_idle", tx_idle, 1);
        status_read("ignored_write_status", 8'h02);
        quiet("ignored_write_quiet", 40);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
